// File: rtl/wbmdio_pkg.sv
// Shared types and MDIO frame constants for the Wishbone-to-MDIO bridge.
package wbmdio_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StCmd,
      StTa,
      StData,
      StAck
   } state_e;

   localparam logic [1:0]  ST         = 2'b01;
   localparam logic [1:0]  OP_RD      = 2'b10;
   localparam logic [1:0]  OP_WR      = 2'b01;
   localparam logic [1:0]  TA_WR      = 2'b10;
   localparam int unsigned FRAME_BITS = 32;

   // Index of the final bit of each serial phase, as counted by bit_cnt.
   function automatic logic [5:0] last_bit(state_e s, int unsigned pre_len);
      case (s)
         StPre:   return 6'(pre_len - 1);
         StCmd:   return 6'd13;
         StTa:    return 6'd1;
         default: return 6'd15;
      endcase
   endfunction

endpackage

// File: rtl/wbmdio_clkgen.sv
// MDC generator: CLKDIV cycles low then CLKDIV cycles high per bit while i_run is set,
// with single-cycle strobes on the cycles where MDC rises and falls.
module wbmdio_clkgen #(
   parameter int unsigned CLKDIV = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   output logic o_mdclk,
   output logic o_fall,
   output logic o_rise
);

   logic [7:0] cnt;
   logic       at_end;

   assign at_end = (cnt == 8'(CLKDIV - 1));
   assign o_rise = i_run & ~o_mdclk & at_end;
   assign o_fall = i_run & o_mdclk & at_end;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt     <= 8'd0;
         o_mdclk <= 1'b0;
      end else if (!i_run) begin
         cnt     <= 8'd0;
         o_mdclk <= 1'b0;
      end else if (at_end) begin
         cnt     <= 8'd0;
         o_mdclk <= ~o_mdclk;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/wbmdio.sv
// Wishbone pipelined slave that runs one clause-22 MDIO read or write frame per request.
// Define WBMDIO_TACHECK_EN to flag reads whose second turnaround bit is not pulled low.
module wbmdio
   import wbmdio_pkg::*;
#(
   parameter int unsigned CLKDIV       = 2,
   parameter int unsigned PREAMBLE_LEN = 32
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [9:0]  i_wb_addr,
   input  logic [15:0] i_wb_data,
   output logic        o_wb_ack,
   output logic        o_wb_stall,
   output logic [31:0] o_wb_data,
   output logic        o_mdclk,
   output logic        o_mdio,
   output logic        o_mdwe,
   input  logic        i_mdio
);

   state_e                state, next_st, ent_st;
   logic [5:0]            bit_cnt;
   logic [FRAME_BITS-1:0] frame, tx_sr;
   logic [15:0]           rx_sr, rdata;
   logic                  we_q, cyc_ok, err;
   logic                  run, fall, rise, done, accept;

   assign run    = (state != StIdle) && (state != StAck);
   assign accept = (state == StIdle) && i_wb_stb;
   // Read frames carry ones after the command so MDIO idles high once released.
   assign frame  = {ST, i_wb_we ? OP_WR : OP_RD, i_wb_addr, i_wb_we ? TA_WR : 2'b11,
                    i_wb_we ? i_wb_data : 16'hFFFF};

   wbmdio_clkgen #(
      .CLKDIV(CLKDIV)
   ) u_clkgen (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_run  (run),
      .o_mdclk(o_mdclk),
      .o_fall (fall),
      .o_rise (rise)
   );

   always_comb begin
      done = fall && (bit_cnt == last_bit(state, PREAMBLE_LEN));
      case (state)
         StPre:   next_st = StCmd;
         StCmd:   next_st = StTa;
         StTa:    next_st = StData;
         StData:  next_st = StAck;
         default: next_st = state;
      endcase
      ent_st = done ? next_st : state;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= StIdle;
         bit_cnt    <= 6'd0;
         tx_sr      <= '0;
         rx_sr      <= 16'd0;
         rdata      <= 16'd0;
         we_q       <= 1'b0;
         cyc_ok     <= 1'b0;
         o_wb_ack   <= 1'b0;
         o_wb_stall <= 1'b0;
         o_mdio     <= 1'b1;
         o_mdwe     <= 1'b0;
      end else begin
         o_wb_ack <= 1'b0;
         if (state != StIdle) cyc_ok <= cyc_ok & i_wb_cyc;
         if (rise && state == StData) rx_sr <= {rx_sr[14:0], i_mdio};
         case (state)
            StIdle: begin
               if (accept) begin
                  we_q       <= i_wb_we;
                  cyc_ok     <= i_wb_cyc;
                  o_wb_stall <= 1'b1;
                  o_mdwe     <= 1'b1;
                  bit_cnt    <= 6'd0;
                  if (PREAMBLE_LEN == 0) begin
                     state  <= StCmd;
                     o_mdio <= frame[FRAME_BITS-1];
                     tx_sr  <= {frame[FRAME_BITS-2:0], 1'b0};
                  end else begin
                     state  <= StPre;
                     o_mdio <= 1'b1;
                     tx_sr  <= frame;
                  end
               end
            end
            StPre, StCmd, StTa, StData: begin
               if (fall) begin
                  state   <= ent_st;
                  bit_cnt <= done ? 6'd0 : bit_cnt + 6'd1;
                  if (ent_st == StAck) begin
                     o_mdio   <= 1'b1;
                     o_mdwe   <= 1'b0;
                     o_wb_ack <= cyc_ok & i_wb_cyc;
                     if (!we_q) rdata <= rx_sr;
                  end else if (ent_st != StPre) begin
                     o_mdio <= tx_sr[FRAME_BITS-1];
                     tx_sr  <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                     if (ent_st == StTa && !we_q) o_mdwe <= 1'b0;
                  end
               end
            end
            default: begin
               state      <= StIdle;
               o_wb_stall <= 1'b0;
            end
         endcase
      end
   end

`ifdef WBMDIO_TACHECK_EN
   // A responding PHY pulls the second turnaround bit low.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err <= 1'b0;
      end else if (accept && !i_wb_we) begin
         err <= 1'b0;
      end else if (rise && state == StTa && bit_cnt == 6'd1 && !we_q) begin
         err <= i_mdio;
      end
   end
`else
   assign err = 1'b0;
`endif

   assign o_wb_data = {15'h0, err, rdata};

endmodule

// File: tb/tb_wbmdio.sv
// Directed bench for wbmdio: default build (CLKDIV=2, 32-bit preamble) plus a
// CLKDIV=3 / no-preamble instance; honours WBMDIO_TACHECK_EN in its expectations.
module tb_wbmdio;

   typedef struct {
      logic        sel;
      logic        we;
      logic [9:0]  addr;
      logic [15:0] wdata;
      logic [15:0] phy;
      logic        ta;
      int          pre;
      int          lat;
      int          nbits;
      logic [63:0] frame;
      logic [63:0] mdwe;
      logic [31:0] wbd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n, cyc, stb, we, sel, mdio_in;
   logic [9:0]  addr;
   logic [15:0] wdata;
   logic        ack0, stall0, mdclk0, mdio0, mdwe0;
   logic        ack1, stall1, mdclk1, mdio1, mdwe1;
   logic [31:0] wbd0, wbd1;
   logic        stb0, stb1, ack_s, stall_s, mdclk_s, mdio_s, mdwe_s;
   logic [31:0] wbd_s;

   int          n_checks = 0, n_fail = 0;
   int          ncyc, nrise, ack_cnt, ack_at, stall_fall, phy_pre;
   logic        prev_clk, stall_at1, phy_ta;
   logic [15:0] phy_word;
   logic [63:0] rec_bits, rec_we;
   vec_t        vecs[7];
   vec_t        v;

   always #5 clk = ~clk;

   assign stb0    = stb & ~sel;
   assign stb1    = stb & sel;
   assign ack_s   = sel ? ack1 : ack0;
   assign stall_s = sel ? stall1 : stall0;
   assign mdclk_s = sel ? mdclk1 : mdclk0;
   assign mdio_s  = sel ? mdio1 : mdio0;
   assign mdwe_s  = sel ? mdwe1 : mdwe0;
   assign wbd_s   = sel ? wbd1 : wbd0;

   wbmdio u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb0), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack0), .o_wb_stall(stall0),
      .o_wb_data(wbd0), .o_mdclk(mdclk0), .o_mdio(mdio0), .o_mdwe(mdwe0), .i_mdio(mdio_in)
   );

   wbmdio #(
      .CLKDIV(3),
      .PREAMBLE_LEN(0)
   ) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb1), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_ack(ack1), .o_wb_stall(stall1),
      .o_wb_data(wbd1), .o_mdclk(mdclk1), .o_mdio(mdio1), .o_mdwe(mdwe1), .i_mdio(mdio_in)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // PHY side: pull-up everywhere except a responding TA bit and the read data.
   function automatic logic phy_bit(int k);
      int rel;
      rel = k - phy_pre;
      if (rel == 15) return phy_ta;
      if (rel >= 16 && rel < 32) return phy_word[4'(31 - rel)];
      return 1'b1;
   endfunction

   task automatic tick();
      @(negedge clk);
      ncyc++;
      if (ncyc == 1) stall_at1 = stall_s;
      if (mdclk_s && !prev_clk) begin
         rec_bits = {rec_bits[62:0], mdio_s};
         rec_we   = {rec_we[62:0], mdwe_s};
         nrise++;
      end
      prev_clk = mdclk_s;
      if (ack_s) begin
         ack_cnt++;
         ack_at = ncyc;
      end
      if (!stall_s && stall_fall == 0) stall_fall = ncyc;
      if (!mdclk_s) mdio_in = phy_bit(nrise);
   endtask

   task automatic start(input vec_t t);
      sel      = t.sel;
      phy_word = t.phy;
      phy_ta   = t.ta;
      phy_pre  = t.pre;
      @(negedge clk);
      we    = t.we;
      addr  = t.addr;
      wdata = t.wdata;
      stb   = 1'b1;
      @(posedge clk);
      #1 stb = 1'b0;
      ncyc = 0; nrise = 0; ack_cnt = 0; ack_at = 0; stall_fall = 0;
      prev_clk = 1'b0; rec_bits = '0; rec_we = '0;
   endtask

   task automatic finish_frame();
      while (ncyc < 600 && !(stall_fall != 0 && ncyc >= stall_fall + 2)) tick();
   endtask

   task automatic run_vec(input vec_t t, input string tag);
      start(t);
      finish_frame();
      check({tag, " stall_after_accept"}, 64'(stall_at1), 64'd1);
      check({tag, " ack_latency"}, 64'(ack_at), 64'(t.lat));
      check({tag, " ack_pulses"}, 64'(ack_cnt), 64'd1);
      check({tag, " stall_fall"}, 64'(stall_fall), 64'(t.lat + 1));
      check({tag, " mdc_bits"}, 64'(nrise), 64'(t.nbits));
      check({tag, " mdio_frame"}, rec_bits & t.mdwe, t.frame);
      check({tag, " mdwe_pattern"}, rec_we, t.mdwe);
      check({tag, " wb_data"}, 64'(wbd_s), 64'(t.wbd));
      check({tag, " idle_pins"}, 64'({mdclk_s, mdio_s, mdwe_s}), 64'(3'b010));
   endtask

   localparam logic [63:0] WR_MASK  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] RD_MASK  = 64'hFFFF_FFFF_FFFC_0000;
`ifdef WBMDIO_TACHECK_EN
   localparam logic [31:0] NOPHY_WD = 32'h0001_FFFF;
`else
   localparam logic [31:0] NOPHY_WD = 32'h0000_FFFF;
`endif

   initial begin
      //          sel we  addr    wdata     phy       ta  pre lat  nb  frame                   mdwe     wbd
      vecs[0] = '{1'b0, 1'b1, 10'h021, 16'hA5C3, 16'h0000, 1'b0, 32, 257, 64,
                  64'hFFFF_FFFF_5086_A5C3, WR_MASK, 32'h0000_0000};
      vecs[1] = '{1'b0, 1'b0, 10'h3E2, 16'h0000, 16'h1234, 1'b0, 32, 257, 64,
                  64'hFFFF_FFFF_6F88_0000, RD_MASK, 32'h0000_1234};
      vecs[2] = '{1'b0, 1'b1, 10'h3FF, 16'h0000, 16'h0000, 1'b0, 32, 257, 64,
                  64'hFFFF_FFFF_5FFE_0000, WR_MASK, 32'h0000_1234};
      vecs[3] = '{1'b0, 1'b0, 10'h000, 16'h0000, 16'hBEEF, 1'b0, 32, 257, 64,
                  64'hFFFF_FFFF_6000_0000, RD_MASK, 32'h0000_BEEF};
      vecs[4] = '{1'b0, 1'b0, 10'h155, 16'h0000, 16'hFFFF, 1'b1, 32, 257, 64,
                  64'hFFFF_FFFF_6554_0000, RD_MASK, NOPHY_WD};
      vecs[5] = '{1'b0, 1'b0, 10'h155, 16'h0000, 16'h00A5, 1'b0, 32, 257, 64,
                  64'hFFFF_FFFF_6554_0000, RD_MASK, 32'h0000_00A5};
      vecs[6] = '{1'b1, 1'b1, 10'h021, 16'hA5C3, 16'h0000, 1'b0, 0, 193, 32,
                  64'h0000_0000_5086_A5C3, 64'h0000_0000_FFFF_FFFF, 32'h0000_0000};

      cyc = 1'b1; stb = 1'b0; we = 1'b0; sel = 1'b0; addr = '0; wdata = '0; mdio_in = 1'b1;
      phy_word = '0; phy_ta = 1'b0; phy_pre = 32;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #20;
      check("reset_pins0", 64'({ack0, stall0, mdclk0, mdio0, mdwe0}), 64'(5'b00010));
      check("reset_data0", 64'(wbd0), 64'd0);
      check("reset_pins1", 64'({ack1, stall1, mdclk1, mdio1, mdwe1}), 64'(5'b00010));
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of a read's data phase.
      v = vecs[1];
      start(v);
      while (nrise < 52 && ncyc < 600) tick();
      check("abort_reached_data", 64'(nrise), 64'd52);
      #2 rst_n = 1'b0;
      #1;
      check("abort_pins", 64'({ack0, stall0, mdclk0, mdio0, mdwe0}), 64'(5'b00010));
      check("abort_data", 64'(wbd0), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ack_cnt = 0;
      repeat (300) tick();
      check("abort_no_ack", 64'(ack_cnt), 64'd0);
      run_vec(vecs[1], "after_abort");

      // Bus cycle dropped during CMD, plus a strobe while stalled.
      v = vecs[0];
      start(v);
      while (nrise < 36 && ncyc < 600) tick();
      cyc = 1'b0;
      while (nrise < 40 && ncyc < 600) tick();
      stb = 1'b1;
      tick();
      stb = 1'b0;
      finish_frame();
      cyc = 1'b1;
      check("cycdrop_ack", 64'(ack_cnt), 64'd0);
      check("cycdrop_bits", 64'(nrise), 64'd64);
      check("cycdrop_frame", rec_bits, 64'hFFFF_FFFF_5086_A5C3);
      check("cycdrop_stall_fall", 64'(stall_fall), 64'd258);
      repeat (20) tick();
      check("stalled_stb_ignored", 64'(nrise), 64'd64);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wbmdio.md
WBMDIO -- requirements
Module: wbmdio

Interface
REQ-001 Parameter CLKDIV, default 2: MDC half-period in i_clk cycles; legal range 2..255.
REQ-002 Parameter PREAMBLE_LEN, default 32: number of preamble '1' bits; legal range 0..32.
REQ-003 i_clk  input  1  system clock; the only clock.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  Wishbone classic-pipelined control.
REQ-006 i_wb_addr  input  10  {PHY address[9:5], register address[4:0]}.
REQ-007 i_wb_data  input  16  write data.
REQ-008 o_wb_ack, o_wb_stall  output  1 each  Wishbone handshake.
REQ-009 o_wb_data  output  32  {15'h0, err, rdata[15:0]}.
REQ-010 o_mdclk  output  1  MDC.
REQ-011 o_mdio  output  1  MDIO output value.
REQ-012 o_mdwe  output  1  MDIO output enable; 1 means drive.
REQ-013 i_mdio  input  1  MDIO pad input.

Function
REQ-014 The block accepts a request when i_wb_stb=1 and o_wb_stall=0; it latches we, addr and data on that edge.
REQ-015 o_wb_stall rises on the cycle after acceptance and stays high until the ack cycle; it is 0 in IDLE.
REQ-016 States: IDLE, PRE, CMD, TA, DATA, ACK. Transitions: IDLE->PRE on accept (IDLE->CMD when PREAMBLE_LEN=0), PRE->CMD after PREAMBLE_LEN bits, CMD->TA after 14 bits, TA->DATA after 2 bits, DATA->ACK after 16 bits, ACK->IDLE unconditionally after 1 cycle.
REQ-017 MDC runs only outside IDLE and ACK; each bit is CLKDIV cycles low then CLKDIV cycles high; o_mdclk=0 in IDLE and ACK.
REQ-018 o_mdio changes only at the start of the low phase; i_mdio is sampled on the i_clk cycle of each MDC rising edge.
REQ-019 Frame order, MSB first: preamble 1s, ST=01, OP (10 read, 01 write), PHY[4:0], REG[4:0], TA, DATA[15:0].
REQ-020 Write: TA driven as 10 and DATA driven from the latched data; o_mdwe=1 from PRE through DATA.
REQ-021 Read: o_mdwe=1 through CMD and 0 through TA and DATA; the 16 DATA samples shift into rdata.
REQ-022 o_wb_ack is a single-cycle pulse in ACK, exactly 2*CLKDIV*(PREAMBLE_LEN+32)+1 cycles after the accepting edge.
REQ-023 o_wb_data is updated in ACK for reads only; after a write it holds the last read value.
REQ-024 If i_wb_cyc falls mid-transaction, the frame completes on the wire and the ack is suppressed.
REQ-025 While o_wb_stall=1, i_wb_stb is ignored; no request queueing.
REQ-026 In IDLE, o_mdwe=0 and o_mdio=1.

Reset
REQ-027 Asserting i_rst_n=0 at any time, including mid-frame, forces IDLE, o_mdclk=0, o_mdio=1, o_mdwe=0, o_wb_ack=0, o_wb_stall=0 and o_wb_data=0 without waiting for a clock edge; no ack is issued for an aborted request.

Configuration
REQ-028 With WBMDIO_TACHECK_EN defined, a read samples the second TA bit, and err=1 if that sample is 1 (no PHY responded); err is cleared on every read acceptance.
REQ-029 Without WBMDIO_TACHECK_EN, err is constant 0 and no TA sampling logic exists.

Structure
REQ-030 Package wbmdio_pkg holds the state enumeration, the ST/OP constants (ST=2'b01, OP_RD=2'b10, OP_WR=2'b01, TA_WR=2'b10) and the frame bit count 32.
REQ-031 Sub-module wbmdio_clkgen, parametrised by CLKDIV, generates o_mdclk plus one-cycle fall and rise strobes, and is gated by a run input.

Verification
REQ-032 CLKDIV=2, PREAMBLE_LEN=32, write addr 10'h021 data 16'hA5C3 -> MDIO shows 32 ones then 01 01 00001 00001 10 1010010111000011; ack occurs 257 cycles after accept.
REQ-033 Read addr 10'h3E2 with a PHY model returning 16'h1234 -> o_wb_data=32'h0000_1234 and o_mdwe=0 during the TA and DATA bits.
REQ-034 WBMDIO_TACHECK_EN defined, i_mdio held at 1 during a read -> o_wb_data=32'h0001_FFFF.
REQ-035 PREAMBLE_LEN=0, CLKDIV=3 write -> no preamble; ack occurs 193 cycles after accept.
REQ-036 Reset pulsed during DATA of a read -> outputs take reset values immediately, no ack, and the next request completes normally.
REQ-037 i_wb_cyc dropped during CMD -> the frame completes on MDIO, no ack, and stall falls afterwards.
